// File: rtl/tdm_pkg.sv
// Shared constants and helpers for the multiplexed display path.
// onehot_n builds the active-low anode pattern for one scan slot.
package tdm_pkg;

  localparam int DEF_N_DIGITS = 8;
  localparam int DEF_DATA_W   = 4;
  localparam int DEF_PRESCALE = 100000;
  localparam int MAX_DIGITS   = 16;

  // Bits at or above n stay high so a truncated result is always well formed.
  function automatic logic [MAX_DIGITS-1:0] onehot_n(input int idx, input int n);
    logic [MAX_DIGITS-1:0] pat;
    pat = '1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i == idx && i < n) pat[i] = 1'b0;
    end
    return pat;
  endfunction

endpackage

// File: rtl/tdm_scan_driver_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled clock cycles.
// Dropping enable clears the count, so the first tick after re-enable is PRESCALE cycles out.
module tick_gen
  import tdm_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_scan_driver.sv
// Time-division-multiplexed digit scanner with per-frame snapshot of digit data and mask.
// All outputs are decoded from registers only; they are valid every cycle with no handshake.
module tdm_scan_driver
  import tdm_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PRESCALE = DEF_PRESCALE,
  localparam int IDX_W   = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [N_DIGITS*DATA_W-1:0]   digits,
  input  logic [N_DIGITS-1:0]          digit_en,
  output logic [DATA_W-1:0]            dato,
  output logic [N_DIGITS-1:0]          anode_n,
  output logic [IDX_W-1:0]             idx,
  output logic                         blank,
  output logic                         frame_tick
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic                       tick;
  logic                       wrap;
  logic                       enable_q;
  logic [N_DIGITS*DATA_W-1:0] data_q;
  logic [N_DIGITS-1:0]        mask_q;
  logic                       sel_mask;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign wrap = tick && (idx == LAST_IDX);

  // While disabled the snapshot tracks the inputs, so re-enabling shows fresh data at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      enable_q   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      enable_q   <= enable;
      frame_tick <= wrap;
      if (!enable) begin
        data_q <= digits;
        mask_q <= digit_en;
      end else if (tick) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
        if (wrap) begin
          data_q <= digits;
          mask_q <= digit_en;
        end
      end
    end
  end

  always_comb begin
    dato     = '0;
    sel_mask = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        dato     = data_q[k*DATA_W +: DATA_W];
        sel_mask = mask_q[k];
      end
    end
  end

  assign blank   = !enable_q || !sel_mask;
  assign anode_n = blank ? '1 : N_DIGITS'(onehot_n(32'(idx), N_DIGITS));

endmodule

// File: tb/tb_tdm_scan_driver.sv
// Scoreboard bench for tdm_scan_driver: an 8-digit/PRESCALE=4 instance and a 5-digit/PRESCALE=1 instance.
module tb_tdm_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] D0 = 32'h7654_3210;
  localparam logic [31:0] DF = 32'hFFFF_FFFF;
  localparam logic [31:0] D2 = 32'h0F1E_2D3C;

  logic        rst_n;
  logic        enable;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [3:0]  dato;
  logic [7:0]  anode_n;
  logic [2:0]  idx;
  logic        blank;
  logic        frame_tick;

  logic        enable5;
  logic [19:0] digits5;
  logic [4:0]  digit_en5;
  logic [3:0]  dato5;
  logic [4:0]  anode5;
  logic [2:0]  idx5;
  logic        blank5;
  logic        frame_tick5;

  tdm_scan_driver #(.N_DIGITS(8), .DATA_W(4), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .digit_en(digit_en),
    .dato(dato), .anode_n(anode_n), .idx(idx), .blank(blank), .frame_tick(frame_tick)
  );

  tdm_scan_driver #(.N_DIGITS(5), .DATA_W(4), .PRESCALE(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .enable(enable5), .digits(digits5), .digit_en(digit_en5),
    .dato(dato5), .anode_n(anode5), .idx(idx5), .blank(blank5), .frame_tick(frame_tick5)
  );

  int checks   = 0;
  int failures = 0;

  // {idx, dato, anode_n, blank, frame_tick} expected at each visible output change
  logic [16:0] exp_q[$];
  int          gap_q[$];
  // {idx, dato, anode_n, frame_tick} expected every cycle of the 5-digit run
  logic [12:0] exp5_q[$];
  logic        mon5 = 1'b0;
  int          ft_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] slot(input int k, input logic [31:0] d, input logic [7:0] m,
                                       input logic ft);
    logic [31:0] dd;
    logic [7:0]  a;
    logic        b;
    dd = d >> (k * 4);
    b  = !m[k];
    a  = b ? 8'hFF : ~(8'h01 << k);
    return {3'(k), dd[3:0], a, b, ft};
  endfunction

  task automatic push(input logic [16:0] e, input int gap);
    exp_q.push_back(e);
    gap_q.push_back(gap);
  endtask

  // Monitor for the 8-digit instance: pops one entry per change of the visible outputs.
  logic [15:0] prev;
  logic [15:0] cur;
  int          cyc;
  always @(negedge clk) begin
    cur = {idx, dato, anode_n, blank};
    if (!rst_n) begin
      prev = cur;
      cyc  = 0;
    end else begin
      cyc++;
      if (frame_tick) ft_count++;
      if (cur != prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {15'd0, cur, frame_tick}, 32'hFFFF_FFFF);
        end else begin
          logic [16:0] e;
          int          g;
          e = exp_q.pop_front();
          g = gap_q.pop_front();
          check("slot_outputs", {15'd0, cur, frame_tick}, {15'd0, e});
          if (g != 0) check("slot_gap", cyc, g);
        end
        prev = cur;
        cyc  = 0;
      end else if (frame_tick) begin
        check("stray_frame_tick", {31'd0, frame_tick}, 32'd0);
      end
    end
  end

  // Monitor for the 5-digit instance: one entry per cycle while armed.
  always @(negedge clk) begin
    if (mon5) begin
      if (exp5_q.size() == 0) begin
        check("dut5_unexpected", {19'd0, idx5, dato5, anode5, frame_tick5}, 32'hFFFF_FFFF);
      end else begin
        check("dut5_cycle", {19'd0, idx5, dato5, anode5, frame_tick5}, {19'd0, exp5_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    digits    = D0;
    digit_en  = 8'hFF;
    enable5   = 1'b0;
    digits5   = 20'h43210;
    digit_en5 = 5'h1F;
    #1 rst_n = 1'b0;
    #20;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(3);

    // Frame 1: scan turns on at idx 0, advances every 4 cycles, wraps with frame_tick.
    push(slot(0, D0, 8'hFF, 1'b0), 0);
    for (int k = 1; k < 8; k++) push(slot(k, D0, 8'hFF, 1'b0), (k == 1) ? 3 : 4);
    push(slot(0, D0, 8'hFF, 1'b1), 4);
    // Frame 2: digits change at idx 3 but this frame keeps the old snapshot.
    for (int k = 1; k < 8; k++) push(slot(k, D0, 8'hFF, 1'b0), 4);
    push(slot(0, DF, 8'hFF, 1'b1), 4);
    // Frame 3: all F; new data and mask arrive mid-frame, invisible here.
    for (int k = 1; k < 8; k++) push(slot(k, DF, 8'hFF, 1'b0), 4);
    push(slot(0, D2, 8'hAA, 1'b1), 4);
    // Frame 4: even digits blanked; enable drops at idx 5 for 10 cycles.
    for (int k = 1; k < 6; k++) push(slot(k, D2, 8'hAA, 1'b0), 4);
    push({3'd5, 4'h1, 8'hFF, 1'b1, 1'b0}, 2);
    push(slot(5, D2, 8'hAA, 1'b0), 10);
    push(slot(6, D2, 8'hAA, 1'b0), 3);
    push(slot(7, D2, 8'hAA, 1'b0), 4);
    push(slot(0, D2, 8'hAA, 1'b1), 4);
    push(slot(1, D2, 8'hAA, 1'b0), 4);

    enable = 1'b1;
    cycle(45);
    digits = DF;
    cycle(25);
    digits   = D2;
    digit_en = 8'hAA;
    cycle(47);
    enable = 1'b0;
    cycle(10);
    enable = 1'b1;
    cycle(17);

    // Asynchronous reset in the middle of the scan (idx is 1 here).
    rst_n = 1'b0;
    #1;
    check("rst_anode", {24'd0, anode_n}, 32'h0000_00FF);
    check("rst_blank", {31'd0, blank}, 32'd1);
    check("rst_idx", {29'd0, idx}, 32'd0);
    check("rst_dato", {28'd0, dato}, 32'd0);
    check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    check("scan_queue_drained", exp_q.size(), 0);
    check("frame_tick_count", ft_count, 4);

    // Out of reset with enable low: the snapshot reloads on the first edge, still dark.
    enable = 1'b0;
    push({3'd0, 4'hC, 8'hFF, 1'b1, 1'b0}, 0);
    #20;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(3);
    check("reload_queue_drained", exp_q.size(), 0);

    // Five digits, advance every cycle: 1,2,3,4,0,... with frame_tick on each 0.
    for (int i = 1; i <= 15; i++) begin
      logic [4:0] a5;
      a5 = ~(5'b00001 << (i % 5));
      exp5_q.push_back({3'(i % 5), 4'(i % 5), a5, (i % 5) == 0});
    end
    enable5 = 1'b1;
    cycle(1);
    mon5 = 1'b1;
    cycle(15);
    mon5    = 1'b0;
    enable5 = 1'b0;
    check("dut5_queue_drained", exp5_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_scan_driver.md
Name: tdm_scan_driver

Overview:
- Parametrised time-division-multiplexed display driver for the 7-segment path of the calculator.
- Generates its own digit-scan index from a prescaled clock and selects one DATA_W-bit digit from a packed bus.
- Drives one-hot active-low anodes with per-digit blanking.
- Snapshots the digit data once per frame so a digit never tears mid-scan; feeds the segment decoder downstream.

Parameters:
- N_DIGITS, 8, number of multiplexed digits; legal 2..16.
- DATA_W, 4, bits per digit; legal >= 1.
- PRESCALE, 100000, clk cycles per digit slot; legal >= 1 (1 = advance every cycle).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low = display off, scan frozen.
- digits  in  N_DIGITS*DATA_W  packed digit data; digit k at bits [k*DATA_W +: DATA_W].
- digit_en  in  N_DIGITS  per-digit enable mask; 0 = blank that digit.
- dato  out  DATA_W  data of currently scanned digit.
- anode_n  out  N_DIGITS  one-hot active-low anode select.
- idx  out  clog2(N_DIGITS)  current scan index.
- blank  out  1  high when current slot is dark (mask bit 0 or enable low).
- frame_tick  out  1  one-cycle pulse when idx wraps N_DIGITS-1 -> 0.

Behaviour:
- Widths: CNT_W = max(1, clog2(PRESCALE)); IDX_W = max(1, clog2(N_DIGITS)).
- State registers: prescaler cnt, idx, data_q (snapshot of digits), mask_q (snapshot of digit_en), frame_tick.
- Reset (async, rst_n=0): cnt=0, idx=0, data_q=0, mask_q=0, frame_tick=0. Outputs during reset: dato=0, anode_n=all ones, blank=1, idx=0.
- Prescaler:
  - With enable=1, cnt counts 0..PRESCALE-1 and wraps.
  - tick = (enable && cnt==PRESCALE-1).
  - PRESCALE=1: tick every enabled cycle.
- Index:
  - On tick, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
  - Non-power-of-two N_DIGITS never reaches idx >= N_DIGITS.
- frame_tick is registered: high for exactly one cycle, the cycle after the wrap edge (aligned with idx==0 first appearing).
- Snapshot:
  - data_q/mask_q load from digits/digit_en on the wrap tick, i.e. same edge idx goes to 0.
  - data_q/mask_q also load on every cycle while enable=0.
  - No other loads; input changes mid-frame are invisible until the next frame.
- enable=0:
  - cnt cleared to 0; idx held.
  - anode_n=all ones, blank=1; dato still = data_q[idx].
- enable rising: first tick occurs PRESCALE cycles later; scan resumes from held idx.
- Outputs:
  - Decoded combinationally from registers only; no combinational path from any input to any output.
  - dato = data_q[idx].
  - anode_n = all ones if blank, else ~(1 << idx).
  - blank = !enable_q || !mask_q[idx], where enable_q is enable registered once. This makes turn-off and turn-on one cycle latent.
- Simultaneous events: enable falling on a tick edge takes priority; no idx advance that edge.
- Reset mid-scan: immediate async clear; scan restarts at idx 0 with mask cleared (dark) until first wrap or enable-low load.

Decomposition:
- Package tdm_pkg:
  - Default constants DEF_N_DIGITS=8, DEF_DATA_W=4, DEF_PRESCALE=100000.
  - Function onehot_n(idx, n) returning the active-low anode pattern.
- One sub-module: tick_gen (prescaler: clk, rst_n, enable -> tick), reused by other display/timing blocks.

Test Plan:
- Reset values:
  - Stimulus: rst_n=0 mid-run (N_DIGITS=8, PRESCALE=4).
  - Response: anode_n=8'hFF, blank=1, idx=0, dato=0, frame_tick=0 immediately, without waiting for a clk edge.
- Scan order:
  - Stimulus: enable=1, digit_en=8'hFF, digits=32'h76543210, PRESCALE=4.
  - Response: idx advances every 4 cycles 0..7..0; dato equals idx each slot after the first frame; anode_n=8'hFE,8'hFD,...,8'h7F; frame_tick single pulse every 32 cycles.
- Tear-free snapshot:
  - Stimulus: change digits to 32'hFFFFFFFF while idx=3.
  - Response: slots 3..7 still show old values; new value 4'hF appears from idx=0 of the next frame.
- Blanking:
  - Stimulus: digit_en=8'b1010_1010.
  - Response: on even idx, anode_n=8'hFF and blank=1; on odd idx, normal anode pattern.
- Enable gating:
  - Stimulus: drop enable at idx=5 for 10 cycles, then raise.
  - Response: anode_n=8'hFF one cycle after drop; idx holds at 5; after raise, idx=6 exactly 4 cycles later.
- Edge parameters:
  - Stimulus: N_DIGITS=5, PRESCALE=1.
  - Response: idx sequence 0,1,2,3,4,0 every cycle, never 5..7; frame_tick every 5 cycles.
